// File: rtl/irq_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller: FSM states and a lowest-index-wins helper.
// Combinational only; no flow control.
package irq_ctrl_pkg;

    localparam int N_SRC_DEF = 8;
    localparam int VEC_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    // Index 0 is the highest priority, so the lowest set bit wins.
    function automatic logic [VEC_W_DEF-1:0] prio_idx(input logic [N_SRC_DEF-1:0] mask);
        prio_idx = '0;
        for (int i = N_SRC_DEF - 1; i >= 0; i--) begin
            if (mask[i]) prio_idx = VEC_W_DEF'(i);
        end
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit plus an any-bit flag.
// Purely combinational, zero latency; no flow control.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = N_SRC_DEF,
    parameter int W = VEC_W_DEF
) (
    input  logic [N-1:0] mask_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = W'(i);
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/irq_controller.sv
// Edge-latched, maskable, fixed-priority interrupt controller with ack/eoi tracking.
// irq rises 1 cycle after pending (2 after the src edge); IRQ_NESTING_EN enables preemption in SERVICE.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int               N_SRC      = N_SRC_DEF,
    parameter int               VEC_W      = VEC_W_DEF,
    parameter logic [N_SRC-1:0] ENABLE_RST = '1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] src_i,
    input  logic             enable_we_i,
    input  logic [N_SRC-1:0] enable_wd_i,
    output logic [N_SRC-1:0] enable_o,
    output logic             irq_o,
    output logic [VEC_W-1:0] vector_o,
    input  logic             irq_ack_i,
    input  logic             eoi_i,
    output logic [N_SRC-1:0] pending_o,
    output logic [N_SRC-1:0] in_service_o
);

    state_t           state_q;
    logic [N_SRC-1:0] src_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] in_service_q;
    logic             irq_q;
    logic [VEC_W-1:0] vector_q;

    logic [N_SRC-1:0] rise, cand, ack_clr, is_left;
    logic [VEC_W-1:0] cand_idx, is_idx;
    logic             cand_any, is_any, ack_take, preempt;

    irq_prio_enc #(.N(N_SRC), .W(VEC_W)) u_cand_enc (
        .mask_i (cand),
        .idx_o  (cand_idx),
        .any_o  (cand_any)
    );

    irq_prio_enc #(.N(N_SRC), .W(VEC_W)) u_isvc_enc (
        .mask_i (in_service_q),
        .idx_o  (is_idx),
        .any_o  (is_any)
    );

    assign rise      = src_i & ~src_prev_q;
    assign cand      = pending_q & enable_q;
    assign ack_take  = (state_q == REQ) && irq_ack_i;
    assign ack_clr   = ack_take ? (N_SRC'(1) << vector_q) : '0;
    assign is_left   = in_service_q & ~(N_SRC'(1) << is_idx);
    // A fresh edge on the ack cycle re-arms the source it just cleared.
    assign pending_d = (pending_q & ~ack_clr) | rise;
    assign enable_d  = enable_we_i ? enable_wd_i : enable_q;

`ifdef IRQ_NESTING_EN
    assign preempt = cand_any && (!is_any || (cand_idx < is_idx));
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        src_prev_q <= src_i;
        if (!reset_i) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            enable_q     <= ENABLE_RST;
            in_service_q <= '0;
            irq_q        <= 1'b0;
            vector_q     <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            case (state_q)
                IDLE: begin
                    if (cand_any) begin
                        irq_q    <= 1'b1;
                        vector_q <= cand_idx;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        in_service_q <= in_service_q | ack_clr;
                        irq_q        <= 1'b0;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    // eoi wins over a same-cycle preemption; preemption is re-evaluated next cycle.
                    if (eoi_i && is_any) begin
                        in_service_q <= is_left;
                        if (is_left == '0) state_q <= IDLE;
                    end else if (preempt) begin
                        irq_q    <= 1'b1;
                        vector_q <= cand_idx;
                        state_q  <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign enable_o     = enable_q;
    assign irq_o        = irq_q;
    assign vector_o     = vector_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule
